// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Merges ALU results and FIFO-buffered load returns onto the
//               register-file write port and flags pending-write hazards.
//               Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [2:0]               alu_dest,
   input  logic [7:0]               alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [2:0]               ld_dest,
   input  logic [7:0]               ld_data,
   input  logic [2:0]               pend_addr1,
   input  logic [2:0]               pend_addr2,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic                     write_reg,
   output logic                     read_strobe,
   output logic [2:0]               dest_reg,
   output logic [7:0]               dest_reg_data,
   output logic [7:0]               dest_reg_data2,
   output logic [$clog2(DEPTH):0]   ld_count
);

   localparam int              c_AW         = $clog2(DEPTH);
   localparam int              c_SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
   localparam logic [c_AW:0]   c_DEPTH      = (c_AW + 1)'(DEPTH);

   logic [2:0]      r_mem_dest [DEPTH];
   logic [7:0]      r_mem_data [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic [c_SW-1:0] r_starve;
   logic            r_write_reg;
   logic            r_read_strobe;
   logic [2:0]      r_dest_reg;
   logic [7:0]      r_dest_data;
   logic [7:0]      r_dest_data2;

   logic             w_nonempty;
   logic             w_force_load;
   logic             w_alu_acc;
   logic             w_pop;
   logic             w_push;
   logic             w_bypass;
   logic             w_out_busy;
   logic [DEPTH-1:0] w_ent_valid;
   logic [DEPTH-1:0] w_match1;
   logic [DEPTH-1:0] w_match2;

   assign w_nonempty   = (r_count != '0);
   assign w_force_load = w_nonempty && (r_starve == c_STARVE_MAX);
   assign alu_ready    = !w_force_load;
   assign ld_ready     = (r_count < c_DEPTH);
   assign w_alu_acc    = alu_valid && alu_ready;
   assign w_pop        = !w_alu_acc && w_nonempty;

`ifdef WB_LOAD_BYPASS_EN
   assign w_bypass = !w_nonempty && !alu_valid && ld_valid;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = ld_valid && ld_ready && !w_bypass;

   // An entry is live when its distance from the head is below the occupancy.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         logic [c_AW-1:0] w_offset;
         assign w_offset       = c_AW'(i) - r_rd_ptr;
         assign w_ent_valid[i] = ({1'b0, w_offset} < r_count);
         assign w_match1[i]    = w_ent_valid[i] && (r_mem_dest[i] == pend_addr1);
         assign w_match2[i]    = w_ent_valid[i] && (r_mem_dest[i] == pend_addr2);
      end
   endgenerate

   // The registered write only reaches the register file at the next edge.
   assign w_out_busy = r_write_reg || r_read_strobe;
   assign hazard1    = (|w_match1) || (w_out_busy && (r_dest_reg == pend_addr1));
   assign hazard2    = (|w_match2) || (w_out_busy && (r_dest_reg == pend_addr2));

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem_dest[r_wr_ptr] <= ld_dest;
         r_mem_data[r_wr_ptr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_starve      <= '0;
         r_write_reg   <= 1'b0;
         r_read_strobe <= 1'b0;
         r_dest_reg    <= '0;
         r_dest_data   <= '0;
         r_dest_data2  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (c_AW + 1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (c_AW + 1)'(1);
         end

         if (w_alu_acc) begin
            r_write_reg   <= 1'b1;
            r_read_strobe <= 1'b0;
            r_dest_reg    <= alu_dest;
            r_dest_data   <= alu_data;
            if (!w_nonempty) begin
               r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
               r_starve <= r_starve + c_SW'(1);
            end
         end else if (w_pop) begin
            r_write_reg   <= 1'b0;
            r_read_strobe <= 1'b1;
            r_dest_reg    <= r_mem_dest[r_rd_ptr];
            r_dest_data2  <= r_mem_data[r_rd_ptr];
            r_starve      <= '0;
         end else if (w_bypass) begin
            r_write_reg   <= 1'b0;
            r_read_strobe <= 1'b1;
            r_dest_reg    <= ld_dest;
            r_dest_data2  <= ld_data;
            r_starve      <= '0;
         end else begin
            r_write_reg   <= 1'b0;
            r_read_strobe <= 1'b0;
            r_starve      <= '0;
         end
      end
   end

   assign write_reg      = r_write_reg;
   assign read_strobe    = r_read_strobe;
   assign dest_reg       = r_dest_reg;
   assign dest_reg_data  = r_dest_data;
   assign dest_reg_data2 = r_dest_data2;
   assign ld_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Self-checking bench for writeback_unit: vector table, hand
//               sequences and a reference model feeding a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_valid;
   logic       alu_ready;
   logic [2:0] alu_dest;
   logic [7:0] alu_data;
   logic       ld_valid;
   logic       ld_ready;
   logic [2:0] ld_dest;
   logic [7:0] ld_data;
   logic [2:0] pend_addr1;
   logic [2:0] pend_addr2;
   logic       hazard1;
   logic       hazard2;
   logic       write_reg;
   logic       read_strobe;
   logic [2:0] dest_reg;
   logic [7:0] dest_reg_data;
   logic [7:0] dest_reg_data2;
   logic [2:0] ld_count;

   always #5 clk = ~clk;

   writeback_unit #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
      .pend_addr1(pend_addr1), .pend_addr2(pend_addr2), .hazard1(hazard1), .hazard2(hazard2),
      .write_reg(write_reg), .read_strobe(read_strobe), .dest_reg(dest_reg),
      .dest_reg_data(dest_reg_data), .dest_reg_data2(dest_reg_data2), .ld_count(ld_count)
   );

   typedef struct packed { logic [2:0] dest; logic [7:0] data; } ld_t;
   typedef struct packed { logic is_ld; logic [2:0] dest; logic [7:0] data; } sb_t;
   typedef struct {
      logic av; logic [2:0] ad; logic [7:0] adat;
      logic lv; logic [2:0] ldd; logic [7:0] ldat;
      logic [2:0] p1; logic [2:0] p2;
      logic ewr; logic erd; logic [2:0] edest; logic [7:0] edata; int ecnt;
   } vec_t;

   ld_t        mq[$];
   sb_t        sb[$];
   int         m_starve;
   logic       m_wr, m_rd;
   logic [2:0] m_dest;
   logic [7:0] m_d1, m_d2;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       vt[7];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic model_hazard(input logic [2:0] a);
      logic h;
      h = (m_wr || m_rd) && (m_dest == a);
      foreach (mq[i]) if (mq[i].dest == a) h = 1'b1;
      return h;
   endfunction

   // One clock: drive, check combinational outputs, advance model, check results.
   task automatic cycle(input logic r, input logic av, input logic [2:0] ad, input logic [7:0] adat,
                        input logic lv, input logic [2:0] ldd, input logic [7:0] ldat,
                        input logic [2:0] p1, input logic [2:0] p2);
      logic force_ld, acc, byp, lrdy;
      ld_t  e;
      sb_t  s;
      rst = r; alu_valid = av; alu_dest = ad; alu_data = adat;
      ld_valid = lv; ld_dest = ldd; ld_data = ldat; pend_addr1 = p1; pend_addr2 = p2;
      #1;
      force_ld = (mq.size() != 0) && (m_starve == STARVE_LIMIT);
      lrdy     = (mq.size() < DEPTH);
      chk("alu_ready", alu_ready, !force_ld);
      chk("ld_ready", ld_ready, lrdy);
      chk("ld_count", ld_count, mq.size());
      chk("hazard1", hazard1, model_hazard(p1));
      chk("hazard2", hazard2, model_hazard(p2));
      if (r) begin
         mq.delete(); sb.delete();
         m_starve = 0; m_wr = 0; m_rd = 0; m_dest = '0; m_d1 = '0; m_d2 = '0;
      end else begin
         acc = av && !force_ld;
`ifdef WB_LOAD_BYPASS_EN
         byp = (mq.size() == 0) && !av && lv;
`else
         byp = 1'b0;
`endif
         if (acc) begin
            if (mq.size() == 0) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
            m_wr = 1; m_rd = 0; m_dest = ad; m_d1 = adat;
            sb.push_back({1'b0, ad, adat});
         end else if (mq.size() != 0) begin
            e = mq.pop_front();
            m_starve = 0; m_wr = 0; m_rd = 1; m_dest = e.dest; m_d2 = e.data;
            sb.push_back({1'b1, e.dest, e.data});
         end else if (byp) begin
            m_starve = 0; m_wr = 0; m_rd = 1; m_dest = ldd; m_d2 = ldat;
            sb.push_back({1'b1, ldd, ldat});
         end else begin
            m_starve = 0; m_wr = 0; m_rd = 0;
         end
         if (lv && lrdy && !byp) mq.push_back({ldd, ldat});
      end
      @(posedge clk);
      #1;
      chk("strobe_excl", write_reg & read_strobe, 0);
      chk("write_reg", write_reg, m_wr);
      chk("read_strobe", read_strobe, m_rd);
      if ((write_reg || read_strobe) && sb.size() != 0) begin
         s = sb.pop_front();
         chk("sb_kind", read_strobe, s.is_ld);
         chk("sb_dest", dest_reg, s.dest);
         if (s.is_ld) chk("sb_data2", dest_reg_data2, s.data);
         else         chk("sb_data", dest_reg_data, s.data);
      end else begin
         sb.delete();
         chk("hold_dest", dest_reg, m_dest);
         chk("hold_data", dest_reg_data, m_d1);
         chk("hold_data2", dest_reg_data2, m_d2);
      end
   endtask

   task automatic idle(input int n, input logic [2:0] p1, input logic [2:0] p2);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, p1, p2);
   endtask

   initial begin
      int exp_cnt;
      vt[0] = '{1'b1, 3'd5, 8'hA7, 1'b0, 3'd0, 8'h00, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 8'hA7, 0};
      vt[1] = '{1'b1, 3'd3, 8'h11, 1'b1, 3'd2, 8'h3C, 3'd2, 3'd3, 1'b1, 1'b0, 3'd3, 8'h11, 1};
      vt[2] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, 1'b1, 3'd2, 8'h3C, 0};
      vt[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b0, 1'b0, 3'd2, 8'h11, 0};
      vt[4] = '{1'b1, 3'd1, 8'h22, 1'b1, 3'd6, 8'h55, 3'd6, 3'd1, 1'b1, 1'b0, 3'd1, 8'h22, 1};
      vt[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 1'b0, 1'b1, 3'd6, 8'h55, 0};
      vt[6] = '{1'b1, 3'd7, 8'hFF, 1'b0, 3'd0, 8'h00, 3'd7, 3'd6, 1'b1, 1'b0, 3'd7, 8'hFF, 0};

      mq.delete(); sb.delete();
      m_starve = 0; m_wr = 0; m_rd = 0; m_dest = '0; m_d1 = '0; m_d2 = '0;
      rst = 1'b1; alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 8'h99;
      ld_valid = 1'b1; ld_dest = 3'd4; ld_data = 8'h66; pend_addr1 = '0; pend_addr2 = '0;
      @(posedge clk);
      #1;
      // Second reset cycle with both sources still requesting.
      cycle(1, 1, 3'd4, 8'h99, 1, 3'd4, 8'h66, 3'd4, 3'd0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_read_strobe", read_strobe, 0);
      chk("rst_dest_reg", dest_reg, 0);
      chk("rst_ld_count", ld_count, 0);

      for (int i = 0; i < 7; i++) begin
         cycle(0, vt[i].av, vt[i].ad, vt[i].adat, vt[i].lv, vt[i].ldd, vt[i].ldat, vt[i].p1, vt[i].p2);
         chk("tv_write_reg", write_reg, vt[i].ewr);
         chk("tv_read_strobe", read_strobe, vt[i].erd);
         chk("tv_dest_reg", dest_reg, vt[i].edest);
         chk("tv_data", vt[i].erd ? dest_reg_data2 : dest_reg_data, vt[i].edata);
         chk("tv_ld_count", ld_count, vt[i].ecnt);
      end

      // Single load with no ALU traffic; hazard tracked on register 2.
      cycle(0, 0, 0, 0, 1, 3'd2, 8'h3C, 3'd2, 3'd0);
`ifdef WB_LOAD_BYPASS_EN
      exp_cnt = 0;
`else
      exp_cnt = 1;
`endif
      chk("load_count", ld_count, exp_cnt);
      idle(3, 3'd2, 3'd0);

      // Fill the FIFO under continuous ALU pressure, then watch forced drain order.
      for (int i = 1; i <= 4; i++)
         cycle(0, 1, 3'd0, 8'(8'h10 + i), 1, 3'(i), 8'(8'h40 + i), 3'd1, 3'd4);
      chk("full_ld_ready", ld_ready, 0);
      chk("full_ld_count", ld_count, 4);
      cycle(0, 1, 3'd7, 8'h77, 1, 3'd5, 8'h45, 3'd5, 3'd1);
      chk("forced_load_dest", dest_reg, 1);
      for (int i = 0; i < 14; i++) cycle(0, 1, 3'd6, 8'(8'h60 + i), 0, 0, 0, 3'd3, 3'd4);
      idle(4, 3'd4, 3'd6);

      // Six more loads to carry the pointers past the wrap point.
      for (int i = 0; i < 6; i++)
         cycle(0, logic'(i % 2), 3'd7, 8'(8'hC0 + i), 1, 3'(i), 8'(8'h80 + i), 3'(i), 3'd7);
      idle(6, 3'd5, 3'd0);

      // Push and pop in the same cycle with two entries queued.
      cycle(0, 1, 3'd0, 8'h01, 1, 3'd1, 8'hA1, 3'd1, 3'd2);
      cycle(0, 1, 3'd0, 8'h02, 1, 3'd2, 8'hA2, 3'd1, 3'd2);
      cycle(0, 0, 3'd0, 8'h00, 1, 3'd3, 8'hA3, 3'd3, 3'd2);
      chk("pushpop_count", ld_count, 2);
      idle(3, 3'd3, 3'd2);

      for (int i = 0; i < 60; i++)
         cycle(0, logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               logic'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      idle(6, 3'd0, 3'd1);

      // Reset with three loads still queued.
      cycle(0, 1, 3'd0, 8'h31, 1, 3'd4, 8'hB4, 3'd4, 3'd5);
      cycle(0, 1, 3'd0, 8'h32, 1, 3'd5, 8'hB5, 3'd4, 3'd5);
      cycle(0, 1, 3'd0, 8'h33, 1, 3'd6, 8'hB6, 3'd4, 3'd5);
      chk("pre_rst_count", ld_count, 3);
      cycle(1, 1, 3'd0, 8'h34, 1, 3'd6, 8'hB7, 3'd4, 3'd5);
      chk("midrst_count", ld_count, 0);
      chk("midrst_read_strobe", read_strobe, 0);
      idle(3, 3'd4, 3'd6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
